// File: rtl/fall_evt_pkg.sv
// Shared constants and FSM state type for the falling-edge event reporter.
// Optional per-event timestamps are enabled by defining FALL_EVT_TIMESTAMP_EN.
package fall_evt_pkg;

    localparam int FALL_EVT_WIDTH = 32;
    localparam int FALL_EVT_IDX_W = 5;
    localparam int FALL_EVT_CNT_W = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } fall_evt_state_e;

endpackage

// File: rtl/fall_event_reporter_rr_find_first.sv
// Combinational round-robin selector: lowest set request at or above ptr,
// wrapping to bit 0, found by a double-width masked priority encode.
module rr_find_first
    import fall_evt_pkg::*;
#(
    parameter int WIDTH = FALL_EVT_WIDTH,
    parameter int IDX_W = FALL_EVT_IDX_W
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [2*WIDTH-1:0] dbl;

    always_comb begin
        dbl   = '0;
        found = 1'b0;
        idx   = '0;
        // Lower copy holds only bits at/above ptr; upper copy supplies the wrap.
        for (int i = 0; i < WIDTH; i++) begin
            dbl[i]         = req[i] && (i >= int'(ptr));
            dbl[i + WIDTH] = req[i];
        end
        for (int i = 2 * WIDTH - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                found = 1'b1;
                idx   = (i >= WIDTH) ? IDX_W'(i - WIDTH) : IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fall_event_reporter.sv
// Turns rising capture flags into pending events and drains them round-robin
// over valid/ready. Define FALL_EVT_TIMESTAMP_EN to add the evt_ts output.
module fall_event_reporter
    import fall_evt_pkg::*;
#(
    parameter int WIDTH = FALL_EVT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = FALL_EVT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cap_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_idx,
    output logic [WIDTH-1:0] pending,
    output logic [CNT_W-1:0] evt_count,
    output logic             overflow,
`ifdef FALL_EVT_TIMESTAMP_EN
    output logic [15:0]      evt_ts,
`endif
    output logic             dbg_state
);

    // Handshake: evt_valid/evt_idx stay stable until evt_valid & evt_ready
    // in the same cycle; the event is consumed at that rising edge.
    fall_evt_state_e  state_q, state_d;
    logic [WIDTH-1:0] cap_prev_q, cap_prev_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] evt_idx_q, evt_idx_d;
    logic [CNT_W-1:0] evt_count_q, evt_count_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] new_evt, clr_mask, sel_req;
    logic [IDX_W-1:0] nxt_ptr, sel_ptr, sel_idx;
    logic             hs, sel_found;

    assign hs       = (state_q == PRESENT) && evt_ready;
    assign new_evt  = cap_in & ~cap_prev_q;
    assign clr_mask = hs ? (WIDTH'(1) << evt_idx_q) : '0;
    assign nxt_ptr  = (evt_idx_q == IDX_W'(WIDTH - 1)) ? '0 : evt_idx_q + IDX_W'(1);
    // Only already-pending bits compete; this cycle's new events wait a cycle.
    assign sel_req  = pending_q & ~clr_mask;
    assign sel_ptr  = hs ? nxt_ptr : rr_ptr_q;

    rr_find_first #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_sel (
        .req   (sel_req),
        .ptr   (sel_ptr),
        .found (sel_found),
        .idx   (sel_idx)
    );

    always_comb begin
        state_d     = state_q;
        cap_prev_d  = cap_in;
        pending_d   = (pending_q & ~clr_mask) | new_evt;
        overflow_d  = overflow_q | (|(new_evt & pending_q & ~clr_mask));
        rr_ptr_d    = rr_ptr_q;
        evt_idx_d   = evt_idx_q;
        evt_count_d = evt_count_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    evt_idx_d = sel_idx;
                    state_d   = PRESENT;
                end
            end
            PRESENT: begin
                if (hs) begin
                    rr_ptr_d = nxt_ptr;
                    if (evt_count_q != '1) evt_count_d = evt_count_q + CNT_W'(1);
                    if (sel_found) evt_idx_d = sel_idx;
                    else           state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cap_prev_q  <= '0;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            evt_idx_q   <= '0;
            evt_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_prev_q  <= cap_prev_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            evt_idx_q   <= evt_idx_d;
            evt_count_q <= evt_count_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef FALL_EVT_TIMESTAMP_EN
    logic [15:0] ts_cnt_q, ts_cnt_d;
    logic [15:0] ts_mem_q [WIDTH];
    logic [15:0] ts_mem_d [WIDTH];

    always_comb begin
        ts_cnt_d = ts_cnt_q + 16'd1;
        // Load when the bit joins pending (fresh or re-armed over a clear);
        // an overflow hit keeps the first stamp.
        for (int i = 0; i < WIDTH; i++) begin
            ts_mem_d[i] = (new_evt[i] && (!pending_q[i] || clr_mask[i])) ? ts_cnt_q : ts_mem_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_cnt_q <= '0;
            for (int i = 0; i < WIDTH; i++) ts_mem_q[i] <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            for (int i = 0; i < WIDTH; i++) ts_mem_q[i] <= ts_mem_d[i];
        end
    end

    assign evt_ts = ts_mem_q[evt_idx_q];
`endif

    assign evt_valid = (state_q == PRESENT);
    assign evt_idx   = evt_idx_q;
    assign pending   = pending_q;
    assign evt_count = evt_count_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: doc/fall_event_reporter.md
Name: fall_event_reporter

Overview:
- Reader side for the 32-bit falling-edge capture block.
- Watches the capture block's sticky per-bit flags and turns each newly set flag into one pending event.
- Drains pending events one at a time to a downstream consumer over a valid/ready handshake, with round-robin fairness.
- Sits between the capture register and the status/interrupt logic.

Parameters:
- WIDTH, 32, number of capture bits monitored.
- IDX_W, $clog2(WIDTH) = 5, width of the event index.
- CNT_W, 16, width of the accepted-event counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; asserts immediately, deasserted synchronously upstream.
- cap_in  input  WIDTH  sticky capture flags from the capture block; a bit going 0->1 is a new event.
- evt_valid  output  1  an event is presented on evt_idx.
- evt_ready  input  1  consumer accepts the presented event.
- evt_idx  output  IDX_W  bit index of the presented event.
- pending  output  WIDTH  events latched but not yet accepted.
- evt_count  output  CNT_W  number of accepted events, saturating.
- overflow  output  1  sticky; set when a new event hits a bit that is already pending.

Behaviour:
- Reset (reset=0), all outputs and state asynchronously cleared:
  - evt_valid=0, evt_idx=0, pending=0, evt_count=0, overflow=0.
  - Internal cap_prev=0, rr_ptr=0, FSM=IDLE.
- Edge detect:
  - new_evt = cap_in & ~cap_prev.
  - cap_prev <= cap_in every cycle.
  - A flag held high produces exactly one event.
  - A flag that drops (capture block reset) and rises again produces a new event.
- Pending update, every cycle: pending <= (pending & ~clr_mask) | new_evt.
  - clr_mask is one-hot at evt_idx on handshake (evt_valid & evt_ready), otherwise 0.
  - Set beats clear: a new event on the bit being accepted in the same cycle stays pending.
- overflow <= overflow | |(new_evt & pending & ~clr_mask). Cleared only by reset.
- FSM state IDLE:
  - evt_valid=0.
  - If pending != 0, select the lowest set bit at or above rr_ptr, wrapping to bit 0.
  - Register the selection into evt_idx and go to PRESENT.
  - Latency: cap_in rise at edge N -> pending set at N+1 -> evt_valid=1 at N+2.
- FSM state PRESENT:
  - evt_valid=1. evt_idx is held stable while evt_ready=0; no retraction.
  - On handshake: clear that pending bit, rr_ptr <= evt_idx+1 (wraps WIDTH-1 -> 0), evt_count <= evt_count+1 (saturates at all-ones).
  - If other pending bits remain, select the next one and stay in PRESENT, evt_valid held high. Back-to-back throughput is one event per cycle.
  - Otherwise go to IDLE.
- Arbitration considers pending only; new_evt in the current cycle becomes eligible next cycle.
- Reset mid-PRESENT drops the event with no handshake; evt_valid falls asynchronously.
- Width rules: evt_idx is always < WIDTH; rr_ptr is IDX_W wide; wrap is explicit for non-power-of-2 WIDTH.

Optional Feature:
- Macro: FALL_EVT_TIMESTAMP_EN.
- Defined:
  - Adds output evt_ts [15:0] and a free-running 16-bit cycle counter (reset to 0, wraps at 16'hFFFF -> 0).
  - evt_ts is loaded with the counter value in the cycle the event's pending bit was set.
  - It is stored per bit, at the same edge the bit joins pending.
  - It is presented alongside evt_idx and held stable under backpressure.
  - A re-arm that beats a clear (set beats clear) reloads that bit's stored value.
  - On overflow the stored value is kept, first event wins.
- Undefined: no counter and no evt_ts port. All other behaviour is identical.

Decomposition:
- Package fall_evt_pkg holds:
  - constants FALL_EVT_WIDTH=32, FALL_EVT_IDX_W=5, FALL_EVT_CNT_W=16;
  - typedef fsm state enum {IDLE, PRESENT}.
- One sub-module, rr_find_first: combinational round-robin selector.
  - Inputs: req[WIDTH], ptr[IDX_W].
  - Outputs: found, idx[IDX_W].
  - Built as a double-width masked priority encode.

Test Plan:
- Single event:
  - Stimulus: after reset release, cap_in=32'h00000002 at edge N, evt_ready=1.
  - Response: evt_valid=1, evt_idx=1 at N+2; pending=0 and evt_count=1 after the handshake; evt_valid=0 the next cycle.
- Multi-bit and round-robin:
  - Stimulus: cap_in=32'h0000000E in one cycle, evt_ready=1.
  - Response: evt_idx sequence 1,2,3 on consecutive cycles; evt_count=3; rr_ptr=4.
- Backpressure:
  - Stimulus: cap_in=32'h80000001, evt_ready=0 for 5 cycles, then 1.
  - Response: evt_idx=0 held for 5 cycles, then 31, then evt_valid=0.
- Held flag and re-arm:
  - Stimulus: cap_in bit1 held high 10 cycles.
  - Response: exactly one event.
  - Stimulus: bit1 dropped to 0 then set to 1 again.
  - Response: a second event with idx=1.
- Overflow and set-beats-clear:
  - Stimulus: bit 2 pending and unaccepted, cap_in bit2 toggles 1->0->1.
  - Response: overflow=1.
  - Stimulus: new event on bit 5 in the same cycle bit 5 is accepted.
  - Response: bit 5 stays pending and is presented again.
- Asynchronous reset mid-PRESENT:
  - Stimulus: reset=0 asserted between clock edges while evt_valid=1, idx=3.
  - Response: evt_valid, pending and evt_count go to 0 immediately; nothing is presented after release until a new 0->1 on cap_in.
